// File: rtl/tlb_pkg.sv
// Shared TLB sizing, field widths and the stored entry layout.
package tlb_pkg;
  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;
  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;
  localparam int C_W    = 3;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PFN_W-1:0]  pfn0;
    logic [C_W-1:0]    c0;
    logic              d0;
    logic              v0;
    logic [PFN_W-1:0]  pfn1;
    logic [C_W-1:0]    c1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;
endpackage

// File: rtl/tlb_match.sv
// One search port: per-entry tag compare, lowest-index priority pick, page select.
module tlb_match
  import tlb_pkg::*;
(
  input  tlb_entry_t [TLBNUM-1:0] entries,
  input  logic [VPN2_W-1:0]       vpn2,
  input  logic                    odd_page,
  input  logic [ASID_W-1:0]       asid,
  output logic                    found,
  output logic [IDXW-1:0]         index,
  output logic [PFN_W-1:0]        pfn,
  output logic [C_W-1:0]          c,
  output logic                    d,
  output logic                    v
);
  logic [TLBNUM-1:0] match;
  tlb_entry_t        hit;

  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      match[i] = (entries[i].vpn2 == vpn2) &&
                 (entries[i].g || (entries[i].asid == asid));
    end
  end

  // Scan from the top so the lowest matching index is the last one assigned.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (match[i]) begin
        found = 1'b1;
        index = IDXW'(i);
      end
    end
  end

  assign hit = entries[index];

  always_comb begin
    pfn = '0;
    c   = '0;
    d   = 1'b0;
    v   = 1'b0;
    if (found) begin
      if (odd_page) begin
        pfn = hit.pfn1;
        c   = hit.c1;
        d   = hit.d1;
        v   = hit.v1;
      end else begin
        pfn = hit.pfn0;
        c   = hit.c0;
        d   = hit.d0;
        v   = hit.v0;
      end
    end
  end
endmodule

// File: rtl/tlb.sv
// 16-entry fully associative joint TLB: two search ports, one write port, one read port.
module tlb
  import tlb_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,

  input  logic [VPN2_W-1:0] s0_vpn2,
  input  logic              s0_odd_page,
  input  logic [ASID_W-1:0] s0_asid,
  output logic              s0_found,
  output logic [IDXW-1:0]   s0_index,
  output logic [PFN_W-1:0]  s0_pfn,
  output logic [C_W-1:0]    s0_c,
  output logic              s0_d,
  output logic              s0_v,

  input  logic [VPN2_W-1:0] s1_vpn2,
  input  logic              s1_odd_page,
  input  logic [ASID_W-1:0] s1_asid,
  output logic              s1_found,
  output logic [IDXW-1:0]   s1_index,
  output logic [PFN_W-1:0]  s1_pfn,
  output logic [C_W-1:0]    s1_c,
  output logic              s1_d,
  output logic              s1_v,

  input  logic              we,
  input  logic [IDXW-1:0]   w_index,
  input  logic [VPN2_W-1:0] w_vpn2,
  input  logic [ASID_W-1:0] w_asid,
  input  logic              w_g,
  input  logic [PFN_W-1:0]  w_pfn0,
  input  logic [C_W-1:0]    w_c0,
  input  logic              w_d0,
  input  logic              w_v0,
  input  logic [PFN_W-1:0]  w_pfn1,
  input  logic [C_W-1:0]    w_c1,
  input  logic              w_d1,
  input  logic              w_v1,

  input  logic [IDXW-1:0]   r_index,
  output logic [VPN2_W-1:0] r_vpn2,
  output logic [ASID_W-1:0] r_asid,
  output logic              r_g,
  output logic [PFN_W-1:0]  r_pfn0,
  output logic [C_W-1:0]    r_c0,
  output logic              r_d0,
  output logic              r_v0,
  output logic [PFN_W-1:0]  r_pfn1,
  output logic [C_W-1:0]    r_c1,
  output logic              r_d1,
  output logic              r_v1
);
  tlb_entry_t [TLBNUM-1:0] entries;
  tlb_entry_t              r_e;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entries <= '0;
    end else if (we) begin
      entries[w_index] <= '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                            pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                            pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};
    end
  end

  assign r_e    = entries[r_index];
  assign r_vpn2 = r_e.vpn2;
  assign r_asid = r_e.asid;
  assign r_g    = r_e.g;
  assign r_pfn0 = r_e.pfn0;
  assign r_c0   = r_e.c0;
  assign r_d0   = r_e.d0;
  assign r_v0   = r_e.v0;
  assign r_pfn1 = r_e.pfn1;
  assign r_c1   = r_e.c1;
  assign r_d1   = r_e.d1;
  assign r_v1   = r_e.v1;

  tlb_match u_s0 (
    .entries  (entries),
    .vpn2     (s0_vpn2),
    .odd_page (s0_odd_page),
    .asid     (s0_asid),
    .found    (s0_found),
    .index    (s0_index),
    .pfn      (s0_pfn),
    .c        (s0_c),
    .d        (s0_d),
    .v        (s0_v)
  );

  tlb_match u_s1 (
    .entries  (entries),
    .vpn2     (s1_vpn2),
    .odd_page (s1_odd_page),
    .asid     (s1_asid),
    .found    (s1_found),
    .index    (s1_index),
    .pfn      (s1_pfn),
    .c        (s1_c),
    .d        (s1_d),
    .v        (s1_v)
  );
endmodule

// File: tb/tb_tlb.sv
// Self-checking bench for tlb: expected search/read results queued at drive time, compared on sample.
module tb_tlb;
  logic        clk = 1'b0;
  logic        resetn;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic        s0_odd_page, s1_odd_page;
  logic [7:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic        s0_d, s1_d, s0_v, s1_v;
  logic        we;
  logic [3:0]  w_index, r_index;
  logic [18:0] w_vpn2, r_vpn2;
  logic [7:0]  w_asid, r_asid;
  logic        w_g, r_g;
  logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1;
  logic [2:0]  w_c0, w_c1, r_c0, r_c1;
  logic        w_d0, w_v0, w_d1, w_v1, r_d0, r_v0, r_d1, r_v1;

  typedef struct packed {
    logic        found;
    logic [3:0]  index;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } res_t;

  res_t        sb[$];
  logic [77:0] rd_sb[$];
  int          errors = 0;
  int          checks = 0;

  tlb dut (
    .clk(clk), .resetn(resetn),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
  );

  always #5 clk = ~clk;

  function automatic res_t mk(input logic f, input logic [3:0] idx, input logic [19:0] pfn,
                              input logic [2:0] c, input logic d, input logic v);
    return '{found: f, index: idx, pfn: pfn, c: c, d: d, v: v};
  endfunction

  // Drives one search port, queues the expectation, samples 1ns later (combinational path).
  task automatic search(input bit port, input logic [18:0] vpn2, input logic odd,
                        input logic [7:0] asid, input res_t exp, input string name);
    res_t act, e;
    if (port) begin
      s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid;
    end else begin
      s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid;
    end
    sb.push_back(exp);
    #1;
    act = port ? {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}
               : {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v};
    e = sb.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s (s%0d): got %h expected %h", name, port, act, e);
    end
  endtask

  task automatic read_chk(input logic [3:0] idx, input logic [77:0] exp, input string name);
    logic [77:0] act;
    r_index = idx;
    rd_sb.push_back(exp);
    #1;
    act = {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1};
    checks++;
    if (act !== rd_sb.pop_front()) begin
      errors++;
      $display("FAIL %s idx%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                    input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                    input logic d0, input logic v0, input logic [19:0] pfn1,
                    input logic [2:0] c1, input logic d1, input logic v1);
    @(negedge clk);
    we = 1'b1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    read_chk(4'd5, '0, "reset_read");
    search(0, 19'h1, 1'b0, 8'h00, '0, "reset_miss");
    search(1, 19'h0, 1'b0, 8'h00, mk(1'b1, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0), "reset_hit0");
  endtask

  task automatic test_hit();
    wr(4'd3, 19'h12345, 8'h0A, 1'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1, 20'h11111, 3'd2, 1'b0, 1'b1);
    @(negedge clk);
    search(0, 19'h12345, 1'b0, 8'h0A, mk(1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1), "hit_even");
    search(1, 19'h12345, 1'b1, 8'h0A, mk(1'b1, 4'd3, 20'h11111, 3'd2, 1'b0, 1'b1), "hit_odd");
    search(1, 19'h12345, 1'b0, 8'h0A, mk(1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1), "s1_even");
    search(0, 19'h12345, 1'b0, 8'h0B, '0, "asid_miss");
    search(0, 19'h12346, 1'b0, 8'h0A, '0, "vpn_miss");
  endtask

  task automatic test_global();
    wr(4'd3, 19'h12345, 8'h0A, 1'b1, 20'hABCDE, 3'd3, 1'b1, 1'b1, 20'h11111, 3'd2, 1'b0, 1'b1);
    @(negedge clk);
    search(0, 19'h12345, 1'b1, 8'h0B, mk(1'b1, 4'd3, 20'h11111, 3'd2, 1'b0, 1'b1), "global_hit");
  endtask

  task automatic test_multi();
    wr(4'd9, 19'h7F000, 8'h00, 1'b1, 20'h99999, 3'd1, 1'b0, 1'b1, 20'h9999A, 3'd1, 1'b1, 1'b0);
    wr(4'd2, 19'h7F000, 8'h00, 1'b1, 20'h22222, 3'd4, 1'b1, 1'b0, 20'h22223, 3'd5, 1'b0, 1'b1);
    @(negedge clk);
    search(0, 19'h7F000, 1'b0, 8'h55, mk(1'b1, 4'd2, 20'h22222, 3'd4, 1'b1, 1'b0), "multi_s0");
    search(1, 19'h7F000, 1'b1, 8'h00, mk(1'b1, 4'd2, 20'h22223, 3'd5, 1'b0, 1'b1), "multi_s1");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    we = 1'b1; w_index = 4'd3; w_vpn2 = 19'h00001; w_asid = 8'h0A; w_g = 1'b0;
    w_pfn0 = 20'h33333; w_c0 = 3'd6; w_d0 = 1'b0; w_v0 = 1'b1;
    w_pfn1 = 20'h44444; w_c1 = 3'd7; w_d1 = 1'b1; w_v1 = 1'b1;
    search(0, 19'h12345, 1'b0, 8'h0A, mk(1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1), "same_cycle_old");
    read_chk(4'd3, {19'h12345, 8'h0A, 1'b1, 20'hABCDE, 3'd3, 1'b1, 1'b1, 20'h11111, 3'd2, 1'b0, 1'b1},
             "same_cycle_read");
    @(posedge clk);
    #1 we = 1'b0;
    @(negedge clk);
    search(0, 19'h12345, 1'b0, 8'h0A, '0, "after_old_gone");
    search(1, 19'h00001, 1'b1, 8'h0A, mk(1'b1, 4'd3, 20'h44444, 3'd7, 1'b1, 1'b1), "after_new_hit");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++)
      wr(4'(i), 19'(i), 8'(i), 1'b0, 20'(i + 16), 3'd1, 1'b0, 1'b1, 20'(i + 32), 3'd2, 1'b1, 1'b1);
    @(negedge clk);
    read_chk(4'd7, {19'd7, 8'd7, 1'b0, 20'd23, 3'd1, 1'b0, 1'b1, 20'd39, 3'd2, 1'b1, 1'b1}, "fill_read");
    search(0, 19'd12, 1'b0, 8'd12, mk(1'b1, 4'd12, 20'd28, 3'd1, 1'b0, 1'b1), "fill_hit");
    we = 1'b1; w_index = 4'd6; w_vpn2 = 19'h5555; w_v0 = 1'b1;
    #2 resetn = 1'b0;
    @(posedge clk);
    #1 we = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) read_chk(4'(i), '0, "post_reset_read");
    search(0, 19'h5555, 1'b0, 8'h00, '0, "pending_write_lost");
  endtask

  initial begin
    resetn = 1'b0; we = 1'b0;
    s0_vpn2 = '0; s0_odd_page = 1'b0; s0_asid = '0;
    s1_vpn2 = '0; s1_odd_page = 1'b0; s1_asid = '0;
    w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
    w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
    w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
    r_index = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    test_reset();
    test_hit();
    test_global();
    test_multi();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
